common_dispatch_buffer2: RTL and testbench
==========================================

COMMON_DISPATCH_BUFFER2 -- requirements
Module: common_dispatch_buffer2

Interface
REQ-001 Parameter: BUFFER_WIDTH, 32, payload width in bits.
REQ-002 Parameter: BUFFER_DEPTH, 2, entries per output channel; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset; asynchronous assert, active-low.
REQ-005 prev_i_data  input  BUFFER_WIDTH  upstream payload.
REQ-006 prev_i_dest  input  1  target channel (0 -> next0, 1 -> next1); qualified by prev_i_valid.
REQ-007 prev_i_valid  input  1  upstream payload valid.
REQ-008 prev_o_ready  output  1  block accepts the current payload.
REQ-009 next0_o_data  output  BUFFER_WIDTH  channel-0 payload.
REQ-010 next0_o_valid  output  1  channel-0 payload valid.
REQ-011 next0_i_ready  input  1  channel-0 consumer ready.
REQ-012 next1_o_data / next1_o_valid / next1_i_ready SHALL mirror REQ-009..011 for channel 1.

Function
REQ-013 Transfer on any port SHALL occur only on a rising edge where valid and ready are both high.
REQ-014 Each channel SHALL own an independent FIFO of BUFFER_DEPTH entries with an occupancy count of width clog2(BUFFER_DEPTH+1).
REQ-015 prev_o_ready SHALL equal "FIFO[prev_i_dest] not full"; it depends combinationally on prev_i_dest only, never on next*_i_ready.
REQ-016 Accepted payload SHALL be written to FIFO[prev_i_dest]; the other FIFO is unchanged.
REQ-017 nextN_o_valid SHALL be high iff FIFO N is non-empty; nextN_o_data SHALL be the FIFO N head; pop on nextN handshake.
REQ-018 Latency (bypass off): payload accepted at edge k appears on nextN at cycle k+1 if FIFO N was empty.
REQ-019 Push and pop on the same non-full FIFO in one cycle SHALL leave the count unchanged; when full, push is refused (no pass-through).
REQ-020 Read/write pointers SHALL wrap modulo BUFFER_DEPTH; per-channel order preserved; no ordering guarantee across channels.
REQ-021 A full channel SHALL NOT block accepts to the other channel (no head-of-line blocking when prev_i_dest selects a non-full channel).
REQ-022 While valid and not ready, upstream SHALL hold data/dest; the block does not check this.

Reset
REQ-023 resetn low SHALL asynchronously clear both counts and pointers and zero all storage.
REQ-024 During/after reset: next0_o_valid=0, next1_o_valid=0, next0_o_data=0, next1_o_data=0, prev_o_ready=1 (both FIFOs empty).
REQ-025 Reset mid-operation SHALL discard all buffered entries and any handshake coincident with the asserting edge.

Configuration
REQ-026 Macro COMMON_DISPATCH_BUFFER2_BYPASS_EN defined: when FIFO[prev_i_dest] is empty and that channel's next_i_ready is high, a valid input SHALL pass combinationally to that nextN in the same cycle (zero latency) and not be stored.
REQ-027 Bypass defined, FIFO non-empty or consumer not ready: normal REQ-016..018 path.
REQ-028 Macro undefined: no combinational path from prev_* to next*_o_*; all outputs except prev_o_ready registered.

Structure
REQ-029 Package common_dispatch_buffer2_pkg SHALL hold default width/depth constants and channel index constants CH_NEXT0=0, CH_NEXT1=1.
REQ-030 Per-channel storage SHALL be a sub-module common_fifo_sync (width, depth parameters, push/pop/full/empty, async active-low reset), instantiated twice.

Verification
REQ-031 Reset then idle -> prev_o_ready=1, both valids 0, both data 0.
REQ-032 Send 0xA5A5_0001 dest 0, next0_i_ready=1 -> next0 shows it one cycle later (bypass off) or same cycle (bypass on); next1_o_valid stays 0.
REQ-033 next1_i_ready=0, send 0x10,0x11 dest 1, then 0x12 dest 1 -> prev_o_ready=0 for 0x12; send 0x20 dest 0 -> accepted; release next1 -> 0x10,0x11,0x12 in order.
REQ-034 Alternate dest 0/1 for 16 words, random ready on both sides -> each channel's output sequence equals its input subsequence, none lost/duplicated.
REQ-035 FIFO0 holding 1 entry, push dest 0 and pop next0 same cycle -> count stays 1, next head is new word.
REQ-036 Assert resetn low with both FIFOs full -> immediately valids 0, prev_o_ready 1; post-release, no stale data emitted.

Source files
------------

// File: rtl/common_dispatch_buffer2_pkg.sv
// -----------------------------------------------------------------------------
// common_dispatch_buffer2_pkg
// Shared constants for the two-channel dispatch buffer:
//   DEFAULT_BUFFER_WIDTH / DEFAULT_BUFFER_DEPTH - default payload width and
//   per-channel FIFO depth, NUM_CHANNELS - number of output channels,
//   CH_NEXT0 / CH_NEXT1 - values of prev_i_dest that select next0 / next1.
// -----------------------------------------------------------------------------
package common_dispatch_buffer2_pkg;

    localparam int DEFAULT_BUFFER_WIDTH = 32;
    localparam int DEFAULT_BUFFER_DEPTH = 2;
    localparam int NUM_CHANNELS         = 2;

    localparam logic CH_NEXT0 = 1'b0;
    localparam logic CH_NEXT1 = 1'b1;

endpackage

// File: rtl/common_fifo_sync.sv
// -----------------------------------------------------------------------------
// common_fifo_sync
// Single-clock FIFO with registered storage and an occupancy counter.
// Ports:
//   clk        - clock, rising edge active
//   resetn     - asynchronous active-low reset; clears pointers, count, storage
//   push       - write push_data (ignored while full)
//   push_data  - write payload
//   pop        - drop the head entry (ignored while empty)
//   pop_data   - current head entry
//   full       - count == DEPTH
//   empty      - count == 0
// Parameters: WIDTH payload bits, DEPTH entries (power of two, >= 2).
// -----------------------------------------------------------------------------
module common_fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Requests on a full/empty FIFO are dropped here so callers never corrupt state.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap simply by overflowing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/common_dispatch_buffer2.sv
// -----------------------------------------------------------------------------
// common_dispatch_buffer2
// Routes an upstream valid/ready stream into one of two output channels, each
// backed by its own FIFO so a stalled channel never blocks the other.
// Ports:
//   clk, resetn                      - clock and asynchronous active-low reset
//   prev_i_data/dest/valid           - upstream payload, target channel, valid
//   prev_o_ready                     - FIFO selected by prev_i_dest is not full
//   next0_o_data/valid, next0_i_ready - channel 0 output handshake
//   next1_o_data/valid, next1_i_ready - channel 1 output handshake
// Configuration macro: COMMON_DISPATCH_BUFFER2_BYPASS_EN
//   When defined, a payload whose channel FIFO is empty and whose consumer is
//   ready is forwarded combinationally in the same cycle without being stored.
//   When undefined, next*_o_* come only from FIFO registers.
// -----------------------------------------------------------------------------
module common_dispatch_buffer2
    import common_dispatch_buffer2_pkg::*;
#(
    parameter int BUFFER_WIDTH = DEFAULT_BUFFER_WIDTH,
    parameter int BUFFER_DEPTH = DEFAULT_BUFFER_DEPTH
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [BUFFER_WIDTH-1:0] prev_i_data,
    input  logic                    prev_i_dest,
    input  logic                    prev_i_valid,
    output logic                    prev_o_ready,
    output logic [BUFFER_WIDTH-1:0] next0_o_data,
    output logic                    next0_o_valid,
    input  logic                    next0_i_ready,
    output logic [BUFFER_WIDTH-1:0] next1_o_data,
    output logic                    next1_o_valid,
    input  logic                    next1_i_ready
);

    logic [BUFFER_WIDTH-1:0] fifo_head [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] fifo_full;
    logic [NUM_CHANNELS-1:0] fifo_empty;
    logic [NUM_CHANNELS-1:0] fifo_push;
    logic [NUM_CHANNELS-1:0] fifo_pop;
    logic [NUM_CHANNELS-1:0] next_ready;
    logic [NUM_CHANNELS-1:0] next_valid;
    logic                    accept;

    assign next_ready = {next1_i_ready, next0_i_ready};

    // Ready looks only at the addressed FIFO, so a full channel never stalls
    // traffic to the other one, and downstream ready never feeds back upstream.
    assign prev_o_ready = !fifo_full[prev_i_dest];
    assign accept       = prev_i_valid && prev_o_ready;

`ifdef COMMON_DISPATCH_BUFFER2_BYPASS_EN
    logic bypass_hit;

    assign bypass_hit = accept && fifo_empty[prev_i_dest] && next_ready[prev_i_dest];
`endif

    // Output side is the FIFO head; with bypass enabled an empty channel whose
    // consumer is ready takes the live input instead and nothing is stored.
    // A pop request on an empty FIFO (bypass case) is ignored by the FIFO.
    always_comb begin
        next_valid   = ~fifo_empty;
        next0_o_data = fifo_head[CH_NEXT0];
        next1_o_data = fifo_head[CH_NEXT1];
        fifo_push    = '0;
`ifdef COMMON_DISPATCH_BUFFER2_BYPASS_EN
        if (bypass_hit) begin
            next_valid[prev_i_dest] = 1'b1;
            if (prev_i_dest == CH_NEXT0) begin
                next0_o_data = prev_i_data;
            end else begin
                next1_o_data = prev_i_data;
            end
        end else begin
            fifo_push[prev_i_dest] = accept;
        end
`else
        fifo_push[prev_i_dest] = accept;
`endif
        fifo_pop = next_valid & next_ready;
    end

    assign next0_o_valid = next_valid[CH_NEXT0];
    assign next1_o_valid = next_valid[CH_NEXT1];

    common_fifo_sync #(
        .WIDTH (BUFFER_WIDTH),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo_next0 (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push[CH_NEXT0]),
        .push_data (prev_i_data),
        .pop       (fifo_pop[CH_NEXT0]),
        .pop_data  (fifo_head[CH_NEXT0]),
        .full      (fifo_full[CH_NEXT0]),
        .empty     (fifo_empty[CH_NEXT0])
    );

    common_fifo_sync #(
        .WIDTH (BUFFER_WIDTH),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo_next1 (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push[CH_NEXT1]),
        .push_data (prev_i_data),
        .pop       (fifo_pop[CH_NEXT1]),
        .pop_data  (fifo_head[CH_NEXT1]),
        .full      (fifo_full[CH_NEXT1]),
        .empty     (fifo_empty[CH_NEXT1])
    );

endmodule

// File: tb/tb_common_dispatch_buffer2.sv
// -----------------------------------------------------------------------------
// tb_common_dispatch_buffer2
// Directed self-checking bench for common_dispatch_buffer2 (default 32-bit
// payload, depth 2). Honours COMMON_DISPATCH_BUFFER2_BYPASS_EN when defined.
// -----------------------------------------------------------------------------
module tb_common_dispatch_buffer2;

    logic        clk;
    logic        resetn;
    logic [31:0] prev_i_data;
    logic        prev_i_dest;
    logic        prev_i_valid;
    logic        prev_o_ready;
    logic [31:0] next0_o_data;
    logic        next0_o_valid;
    logic        next0_i_ready;
    logic [31:0] next1_o_data;
    logic        next1_o_valid;
    logic        next1_i_ready;

    int checks = 0;
    int fails  = 0;

    common_dispatch_buffer2 #(
        .BUFFER_WIDTH (32),
        .BUFFER_DEPTH (2)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .prev_i_data   (prev_i_data),
        .prev_i_dest   (prev_i_dest),
        .prev_i_valid  (prev_i_valid),
        .prev_o_ready  (prev_o_ready),
        .next0_o_data  (next0_o_data),
        .next0_o_valid (next0_o_valid),
        .next0_i_ready (next0_i_ready),
        .next1_o_data  (next1_o_data),
        .next1_o_valid (next1_o_valid),
        .next1_i_ready (next1_i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic d, input logic [31:0] data,
                                 input logic r0, input logic r1);
        prev_i_valid  = v;
        prev_i_dest   = d;
        prev_i_data   = data;
        next0_i_ready = r0;
        next1_i_ready = r1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          sent;
    int          recv;
    int          cyc;
    logic        rv, rd, r0, r1, er, ev0, ev1, byp0, byp1;
    logic [31:0] rdata;

    initial begin
        resetn = 1'b0;
        applyStimulus(0, 0, 32'h0, 0, 0);
        #10;
        $display("[TB] reset state");
        checkOutput("rst_ready", prev_o_ready, 1);
        checkOutput("rst_v0", next0_o_valid, 0);
        checkOutput("rst_v1", next1_o_valid, 0);
        checkOutput("rst_d0", next0_o_data, 32'h0);
        checkOutput("rst_d1", next1_o_data, 32'h0);
        #8 resetn = 1'b1;
        tick();
        tick();
        checkOutput("idle_ready", prev_o_ready, 1);
        checkOutput("idle_v0", next0_o_valid, 0);
        checkOutput("idle_v1", next1_o_valid, 0);
        checkOutput("idle_d0", next0_o_data, 32'h0);

        $display("[TB] single word to channel 0");
        applyStimulus(1, 0, 32'hA5A5_0001, 1, 0);
        checkOutput("lat_ready", prev_o_ready, 1);
        checkOutput("lat_v1_same", next1_o_valid, 0);
`ifdef COMMON_DISPATCH_BUFFER2_BYPASS_EN
        checkOutput("byp_v0_same", next0_o_valid, 1);
        checkOutput("byp_d0_same", next0_o_data, 32'hA5A5_0001);
        tick();
        applyStimulus(0, 0, 32'h0, 1, 0);
        checkOutput("byp_v0_next", next0_o_valid, 0);
`else
        checkOutput("lat_v0_same", next0_o_valid, 0);
        tick();
        applyStimulus(0, 0, 32'h0, 1, 0);
        checkOutput("lat_v0_next", next0_o_valid, 1);
        checkOutput("lat_d0_next", next0_o_data, 32'hA5A5_0001);
`endif
        checkOutput("lat_v1_next", next1_o_valid, 0);
        tick();
        checkOutput("lat_v0_drained", next0_o_valid, 0);

        $display("[TB] channel 1 full, channel 0 still accepts");
        applyStimulus(1, 1, 32'h10, 0, 0);
        checkOutput("hol_ready_10", prev_o_ready, 1);
        tick();
        applyStimulus(1, 1, 32'h11, 0, 0);
        checkOutput("hol_ready_11", prev_o_ready, 1);
        tick();
        applyStimulus(1, 1, 32'h12, 0, 0);
        checkOutput("hol_ready_12", prev_o_ready, 0);
        checkOutput("hol_v1", next1_o_valid, 1);
        checkOutput("hol_d1_head", next1_o_data, 32'h10);
        applyStimulus(1, 0, 32'h20, 0, 0);
        checkOutput("hol_ready_20", prev_o_ready, 1);
        tick();
        applyStimulus(1, 1, 32'h12, 0, 1);
        checkOutput("hol_ready_12_still", prev_o_ready, 0);
        checkOutput("hol_v0", next0_o_valid, 1);
        checkOutput("hol_d0", next0_o_data, 32'h20);
        checkOutput("hol_drain_10", next1_o_data, 32'h10);
        tick();
        checkOutput("hol_drain_11", next1_o_data, 32'h11);
        checkOutput("hol_ready_after_pop", prev_o_ready, 1);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 1);
        checkOutput("hol_v1_12", next1_o_valid, 1);
        checkOutput("hol_drain_12", next1_o_data, 32'h12);
        tick();
        checkOutput("hol_v1_empty", next1_o_valid, 0);
        applyStimulus(0, 0, 32'h0, 1, 0);
        checkOutput("hol_d0_kept", next0_o_data, 32'h20);
        tick();
        checkOutput("hol_v0_empty", next0_o_valid, 0);

        $display("[TB] simultaneous push and pop on channel 0");
        applyStimulus(1, 0, 32'h30, 0, 0);
        tick();
        applyStimulus(1, 0, 32'h31, 1, 0);
        checkOutput("pp_head_30", next0_o_data, 32'h30);
        checkOutput("pp_ready", prev_o_ready, 1);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 0);
        checkOutput("pp_v0", next0_o_valid, 1);
        checkOutput("pp_head_31", next0_o_data, 32'h31);
        applyStimulus(1, 0, 32'h32, 0, 0);
        checkOutput("pp_ready_count1", prev_o_ready, 1);
        tick();
        applyStimulus(1, 0, 32'h33, 0, 0);
        checkOutput("pp_full_count2", prev_o_ready, 0);
        applyStimulus(0, 0, 32'h0, 1, 0);
        checkOutput("pp_drain_31", next0_o_data, 32'h31);
        tick();
        checkOutput("pp_drain_32", next0_o_data, 32'h32);
        tick();
        checkOutput("pp_v0_empty", next0_o_valid, 0);

        $display("[TB] alternating destinations with random ready");
        sent = 0;
        recv = 0;
        cyc  = 0;
        while ((sent < 16 || q0.size() > 0 || q1.size() > 0) && cyc < 300) begin
            rv    = (sent < 16);
            rd    = sent[0];
            rdata = 32'h100 + sent;
            r0    = 1'($urandom_range(0, 1));
            r1    = 1'($urandom_range(0, 1));
            applyStimulus(rv, rd, rdata, r0, r1);
            er   = rd ? (q1.size() < 2) : (q0.size() < 2);
            byp0 = 1'b0;
            byp1 = 1'b0;
`ifdef COMMON_DISPATCH_BUFFER2_BYPASS_EN
            byp0 = rv && !rd && (q0.size() == 0) && r0;
            byp1 = rv && rd && (q1.size() == 0) && r1;
`endif
            ev0 = (q0.size() > 0) || byp0;
            ev1 = (q1.size() > 0) || byp1;
            checkOutput("rnd_ready", prev_o_ready, er);
            checkOutput("rnd_v0", next0_o_valid, ev0);
            checkOutput("rnd_v1", next1_o_valid, ev1);
            if (ev0) checkOutput("rnd_d0", next0_o_data, byp0 ? rdata : q0[0]);
            if (ev1) checkOutput("rnd_d1", next1_o_data, byp1 ? rdata : q1[0]);
            if (ev0 && r0) begin
                if (!byp0) void'(q0.pop_front());
                recv++;
            end
            if (ev1 && r1) begin
                if (!byp1) void'(q1.pop_front());
                recv++;
            end
            if (rv && er) begin
                if (!rd && !byp0) q0.push_back(rdata);
                if (rd && !byp1) q1.push_back(rdata);
                sent++;
            end
            tick();
            cyc++;
        end
        checkOutput("rnd_no_timeout", 32'(cyc < 300), 1);
        checkOutput("rnd_recv_count", recv, 16);

        $display("[TB] reset with both channels full");
        applyStimulus(1, 0, 32'h40, 0, 0);
        tick();
        applyStimulus(1, 0, 32'h41, 0, 0);
        tick();
        applyStimulus(1, 1, 32'h50, 0, 0);
        tick();
        applyStimulus(1, 1, 32'h51, 0, 0);
        tick();
        applyStimulus(1, 0, 32'h42, 0, 0);
        checkOutput("full_ready0", prev_o_ready, 0);
        applyStimulus(1, 1, 32'h52, 0, 0);
        checkOutput("full_ready1", prev_o_ready, 0);
        resetn = 1'b0;
        #1;
        checkOutput("arst_v0", next0_o_valid, 0);
        checkOutput("arst_v1", next1_o_valid, 0);
        checkOutput("arst_ready", prev_o_ready, 1);
        checkOutput("arst_d0", next0_o_data, 32'h0);
        checkOutput("arst_d1", next1_o_data, 32'h0);
        tick();
        resetn = 1'b1;
        applyStimulus(0, 0, 32'h0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("post_rst_v0", next0_o_valid, 0);
            checkOutput("post_rst_v1", next1_o_valid, 0);
            tick();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
